// File: rtl/vth_rx_pkg.sv
// Shared definitions for the receive-side UDP slot buffer: byte width,
// FSM state encoding and a width helper for occupancy counters.
package vth_rx_pkg;

  localparam int OCT = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    DISCARD = 2'd2
  } rx_state_e;

  // Width needed to hold a count from 0 to n inclusive (n a power of two).
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/rx_slot_ring.sv
// Per-channel ring of frame slots: write/read pointers, occupancy count and
// the stored length/truncation flag of each slot.
module rx_slot_ring
  import vth_rx_pkg::*;
#(
  parameter  int NUM_SLOTS = 4,
  parameter  int LEN_W     = 11,
  localparam int SL_W      = $clog2(NUM_SLOTS),
  localparam int CNT_W     = cnt_w(NUM_SLOTS)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_commit,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_trunc,
  input  logic             i_pop,
  output logic [SL_W-1:0]  o_wr_ptr,
  output logic [SL_W-1:0]  o_rd_ptr,
  output logic [CNT_W-1:0] o_count,
  output logic [LEN_W-1:0] o_head_len,
  output logic             o_head_trunc
);

  logic [SL_W-1:0]      r_wr_ptr;
  logic [SL_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic [LEN_W-1:0]     r_len [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] r_trunc;
  logic                 w_pop_ok;

  // A pop on an empty ring is silently ignored.
  assign w_pop_ok = i_pop && (r_count != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_trunc  <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) r_len[i] <= '0;
    end else begin
      if (i_commit) begin
        r_wr_ptr          <= r_wr_ptr + 1'b1;
        r_len[r_wr_ptr]   <= i_len;
        r_trunc[r_wr_ptr] <= i_trunc;
      end
      if (w_pop_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      // Simultaneous commit and pop leave the occupancy unchanged.
      if (i_commit && !w_pop_ok)      r_count <= r_count + 1'b1;
      else if (!i_commit && w_pop_ok) r_count <= r_count - 1'b1;
    end
  end

  assign o_wr_ptr     = r_wr_ptr;
  assign o_rd_ptr     = r_rd_ptr;
  assign o_count      = r_count;
  assign o_head_len   = r_len[r_rd_ptr];
  assign o_head_trunc = r_trunc[r_rd_ptr];

endmodule

// File: rtl/rx_udp_slot_buffer.sv
// Demultiplexes the UDP payload stream by destination port into per-channel
// rings of fixed-size slots in byte-wide RX memory.
module rx_udp_slot_buffer
  import vth_rx_pkg::*;
#(
  parameter  int NUM_CH     = 4,
  parameter  int NUM_SLOTS  = 4,
  parameter  int SLOT_BYTES = 256,
  parameter  int LEN_W      = 11,
  localparam int CH_W       = $clog2(NUM_CH),
  localparam int SL_W       = $clog2(NUM_SLOTS),
  localparam int OFF_W      = $clog2(SLOT_BYTES),
  localparam int ADDR_W     = CH_W + SL_W + OFF_W,
  localparam int CNT_W      = cnt_w(NUM_SLOTS),
  localparam int BC_W       = OFF_W + 1
) (
  input  logic                 RX_CLK,
  input  logic                 rst_n,
  input  logic [NUM_CH*16-1:0] port_table,
  input  logic [NUM_CH-1:0]    chan_en,
  input  logic [15:0]          rx_dst_port,
  input  logic                 rx_udp_data_v,
  input  logic [OCT-1:0]       rx_udp_data,
  input  logic                 rx_err,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [OCT-1:0]       mem_wdata,
  output logic [NUM_CH-1:0]    rx_irq,
  input  logic [CH_W-1:0]      rd_chan,
  output logic [SL_W-1:0]      rd_slot,
  output logic [LEN_W-1:0]     rd_len,
  output logic                 rd_trunc,
  output logic [CNT_W-1:0]     rd_count,
  input  logic                 pop,
  output logic [15:0]          drop_cnt,
  output rx_state_e            dbg_state
);

  rx_state_e          r_state;
  rx_state_e          w_next;
  logic [CH_W-1:0]    r_ch;
  logic [SL_W-1:0]    r_slot;
  logic [BC_W-1:0]    r_bcnt;
  logic               r_trunc;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [OCT-1:0]     r_mem_wdata;
  logic [NUM_CH-1:0]  r_irq;
  logic [15:0]        r_drop;

  logic               w_hit;
  logic [CH_W-1:0]    w_hit_ch;
  logic               w_full;
  logic               w_start;
  logic               w_drop;
  logic               w_commit;
  logic               w_byte;
  logic               w_in_slot;
  logic [NUM_CH-1:0]  w_commit_vec;
  logic [NUM_CH-1:0]  w_pop_vec;
  logic [SL_W-1:0]    w_wr_ptr   [NUM_CH];
  logic [SL_W-1:0]    w_rd_ptr   [NUM_CH];
  logic [CNT_W-1:0]   w_count    [NUM_CH];
  logic [LEN_W-1:0]   w_head_len [NUM_CH];
  logic [NUM_CH-1:0]  w_head_trunc;

  // Descending scan so the lowest matching enabled channel wins.
  always_comb begin
    w_hit    = 1'b0;
    w_hit_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (chan_en[i] && (port_table[16*i +: 16] == rx_dst_port)) begin
        w_hit    = 1'b1;
        w_hit_ch = CH_W'(i);
      end
    end
  end

  assign w_full    = (w_count[w_hit_ch] == CNT_W'(NUM_SLOTS));
  assign w_in_slot = (r_bcnt < BC_W'(SLOT_BYTES));

  always_ff @(posedge RX_CLK or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (rx_udp_data_v) w_next = (!rx_err && w_hit && !w_full) ? RECV : DISCARD;
      RECV:    if (!rx_udp_data_v) w_next = IDLE;
               else if (rx_err)    w_next = DISCARD;
      DISCARD: if (!rx_udp_data_v) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_start  = 1'b0;
    w_drop   = 1'b0;
    w_commit = 1'b0;
    w_byte   = 1'b0;
    case (r_state)
      IDLE: begin
        w_start = rx_udp_data_v && !rx_err && w_hit && !w_full;
        w_drop  = rx_udp_data_v && (rx_err || (w_hit && w_full));
      end
      RECV: begin
        w_commit = !rx_udp_data_v;
        w_byte   = rx_udp_data_v && !rx_err;
        w_drop   = rx_udp_data_v && rx_err;
      end
      default: ;
    endcase
  end

  // The byte counter saturates at SLOT_BYTES, which is also the committed length.
  always_ff @(posedge RX_CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_ch        <= '0;
      r_slot      <= '0;
      r_bcnt      <= '0;
      r_trunc     <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_irq       <= '0;
      r_drop      <= '0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_start) begin
        r_ch        <= w_hit_ch;
        r_slot      <= w_wr_ptr[w_hit_ch];
        r_bcnt      <= BC_W'(1);
        r_trunc     <= 1'b0;
        r_mem_we    <= 1'b1;
        r_mem_addr  <= {w_hit_ch, w_wr_ptr[w_hit_ch], {OFF_W{1'b0}}};
        r_mem_wdata <= rx_udp_data;
      end else if (w_byte) begin
        if (w_in_slot) begin
          r_bcnt      <= r_bcnt + 1'b1;
          r_mem_we    <= 1'b1;
          r_mem_addr  <= {r_ch, r_slot, r_bcnt[OFF_W-1:0]};
          r_mem_wdata <= rx_udp_data;
        end else begin
          r_trunc <= 1'b1;
        end
      end
      if (w_drop && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
      for (int i = 0; i < NUM_CH; i++) r_irq[i] <= (w_count[i] != '0) && chan_en[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ring
    assign w_commit_vec[g] = w_commit && (r_ch == CH_W'(g));
    assign w_pop_vec[g]    = pop && (rd_chan == CH_W'(g));

    rx_slot_ring #(
      .NUM_SLOTS (NUM_SLOTS),
      .LEN_W     (LEN_W)
    ) u_ring (
      .i_clk        (RX_CLK),
      .i_rst_n      (rst_n),
      .i_commit     (w_commit_vec[g]),
      .i_len        (LEN_W'(r_bcnt)),
      .i_trunc      (r_trunc),
      .i_pop        (w_pop_vec[g]),
      .o_wr_ptr     (w_wr_ptr[g]),
      .o_rd_ptr     (w_rd_ptr[g]),
      .o_count      (w_count[g]),
      .o_head_len   (w_head_len[g]),
      .o_head_trunc (w_head_trunc[g])
    );
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rx_irq    = r_irq;
  assign drop_cnt  = r_drop;
  assign dbg_state = r_state;
  assign rd_slot   = w_rd_ptr[rd_chan];
  assign rd_len    = w_head_len[rd_chan];
  assign rd_trunc  = w_head_trunc[rd_chan];
  assign rd_count  = w_count[rd_chan];

endmodule

// File: tb/tb_rx_udp_slot_buffer.sv
// Directed bench for rx_udp_slot_buffer with default parameters
// (4 channels, 4 slots, 256-byte slots, 12-bit addresses).
module tb_rx_udp_slot_buffer;
  import vth_rx_pkg::*;

  localparam int SLOT_BYTES = 256;

  logic        RX_CLK;
  logic        rst_n;
  logic [63:0] port_table;
  logic [3:0]  chan_en;
  logic [15:0] rx_dst_port;
  logic        rx_udp_data_v;
  logic [7:0]  rx_udp_data;
  logic        rx_err;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [3:0]  rx_irq;
  logic [1:0]  rd_chan;
  logic [1:0]  rd_slot;
  logic [10:0] rd_len;
  logic        rd_trunc;
  logic [2:0]  rd_count;
  logic        pop;
  logic [15:0] drop_cnt;
  rx_state_e   dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int exp_len [4];
  int m_rd, m_wr;

  rx_udp_slot_buffer dut (
    .RX_CLK        (RX_CLK),
    .rst_n         (rst_n),
    .port_table    (port_table),
    .chan_en       (chan_en),
    .rx_dst_port   (rx_dst_port),
    .rx_udp_data_v (rx_udp_data_v),
    .rx_udp_data   (rx_udp_data),
    .rx_err        (rx_err),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .rx_irq        (rx_irq),
    .rd_chan       (rd_chan),
    .rd_slot       (rd_slot),
    .rd_len        (rd_len),
    .rd_trunc      (rd_trunc),
    .rd_count      (rd_count),
    .pop           (pop),
    .drop_cnt      (drop_cnt),
    .dbg_state     (dbg_state)
  );

  // Clock / reset
  initial RX_CLK = 1'b0;
  always #5 RX_CLK = ~RX_CLK;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one frame; at each negedge checks the write produced by the previous byte.
  task automatic send_frame(input logic [15:0] port, input int n, input int err_at,
                            input bit exp_wr, input int exp_ch, input int exp_slot,
                            input logic [7:0] seed, input bit pop_end);
    int  b;
    bit  want;
    for (int k = 0; k <= n; k++) begin
      @(negedge RX_CLK);
      if (k > 0) begin
        b    = k - 1;
        want = exp_wr && (b < SLOT_BYTES) && (err_at < 0 || b < err_at);
        check($sformatf("mem_we b%0d", b), 32'(mem_we), 32'(want));
        if (want) begin
          check($sformatf("mem_addr b%0d", b), 32'(mem_addr), 32'((exp_ch << 10) | (exp_slot << 8) | b));
          check($sformatf("mem_wdata b%0d", b), 32'(mem_wdata), 32'(8'(seed + b)));
        end
      end
      if (k < n) begin
        rx_udp_data_v = 1'b1;
        rx_dst_port   = port;
        rx_udp_data   = 8'(seed + k);
        rx_err        = (k == err_at);
      end else begin
        rx_udp_data_v = 1'b0;
        rx_err        = 1'b0;
        if (pop_end) pop = 1'b1;
      end
    end
  endtask

  task automatic pop_ch(input logic [1:0] ch);
    rd_chan = ch;
    pop     = 1'b1;
    @(negedge RX_CLK);
    pop     = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    port_table    = {16'h3000, 16'h2000, 16'h1234, 16'h1000};
    chan_en       = 4'hF;
    rx_dst_port   = 16'h0;
    rx_udp_data_v = 1'b0;
    rx_udp_data   = 8'h0;
    rx_err        = 1'b0;
    rd_chan       = 2'd0;
    pop           = 1'b0;
    repeat (3) @(negedge RX_CLK);
    rst_n = 1'b1;
    @(negedge RX_CLK);

    // Reset state
    check("rst mem_we", 32'(mem_we), 32'd0);
    check("rst mem_addr", 32'(mem_addr), 32'd0);
    check("rst mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst rx_irq", 32'(rx_irq), 32'd0);
    check("rst drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst rd_count", 32'(rd_count), 32'd0);
    check("rst state", 32'(dbg_state), 32'(IDLE));

    // 40-byte frame to ch1 (port 0x1234)
    rd_chan = 2'd1;
    send_frame(16'h1234, 40, -1, 1'b1, 1, 0, 8'h10, 1'b0);
    @(negedge RX_CLK);
    check("f40 rd_count", 32'(rd_count), 32'd1);
    check("f40 rd_len", 32'(rd_len), 32'd40);
    check("f40 rd_trunc", 32'(rd_trunc), 32'd0);
    check("f40 rd_slot", 32'(rd_slot), 32'd0);
    check("f40 irq before", 32'(rx_irq), 32'd0);
    @(negedge RX_CLK);
    check("f40 irq after", 32'(rx_irq), 32'h2);

    // 300-byte frame truncated to 256 in ch1 slot 1
    send_frame(16'h1234, 300, -1, 1'b1, 1, 1, 8'h80, 1'b0);
    @(negedge RX_CLK);
    check("f300 rd_count", 32'(rd_count), 32'd2);
    check("f300 head len", 32'(rd_len), 32'd40);
    pop_ch(2'd1);
    check("f300 rd_slot", 32'(rd_slot), 32'd1);
    check("f300 rd_len", 32'(rd_len), 32'd256);
    check("f300 rd_trunc", 32'(rd_trunc), 32'd1);
    check("f300 rd_count", 32'(rd_count), 32'd1);
    pop_ch(2'd1);
    check("ch1 empty", 32'(rd_count), 32'd0);
    @(negedge RX_CLK);
    check("ch1 irq clear", 32'(rx_irq), 32'd0);
    pop_ch(2'd1);
    check("pop empty ignored", 32'(rd_count), 32'd0);
    check("pop empty rd_slot", 32'(rd_slot), 32'd2);

    // Five frames to ch0 with no pop: fifth is dropped as full
    for (int f = 0; f < 5; f++)
      send_frame(16'h1000, 20, -1, (f < 4), 0, f, 8'(8'h20 + 8'(f)), 1'b0);
    @(negedge RX_CLK);
    rd_chan = 2'd0;
    #1;
    check("full rd_count", 32'(rd_count), 32'd4);
    check("full drop_cnt", 32'(drop_cnt), 32'd1);
    check("full rx_irq", 32'(rx_irq), 32'h1);
    for (int s = 0; s < 4; s++) exp_len[s] = 20;

    // rx_err at byte 10 on ch2, then a clean frame lands in the same slot
    rd_chan = 2'd2;
    send_frame(16'h2000, 20, 10, 1'b1, 2, 0, 8'h40, 1'b0);
    @(negedge RX_CLK);
    check("err rd_count", 32'(rd_count), 32'd0);
    check("err drop_cnt", 32'(drop_cnt), 32'd2);
    send_frame(16'h2000, 15, -1, 1'b1, 2, 0, 8'h50, 1'b0);
    @(negedge RX_CLK);
    check("after err rd_count", 32'(rd_count), 32'd1);
    check("after err rd_slot", 32'(rd_slot), 32'd0);
    check("after err rd_len", 32'(rd_len), 32'd15);
    @(negedge RX_CLK);
    check("irq ch0 ch2", 32'(rx_irq), 32'h5);

    // Pop coinciding with commit on ch0
    pop_ch(2'd0);
    check("pre-commit rd_count", 32'(rd_count), 32'd3);
    check("pre-commit rd_slot", 32'(rd_slot), 32'd1);
    send_frame(16'h1000, 12, -1, 1'b1, 0, 0, 8'h60, 1'b1);
    @(negedge RX_CLK);
    pop = 1'b0;
    exp_len[0] = 12;
    check("co-pop rd_count", 32'(rd_count), 32'd3);
    check("co-pop rd_slot", 32'(rd_slot), 32'd2);
    check("co-pop rd_len", 32'(rd_len), 32'd20);
    send_frame(16'h1000, 9, -1, 1'b1, 0, 1, 8'h70, 1'b0);
    exp_len[1] = 9;
    @(negedge RX_CLK);
    check("co-pop refill count", 32'(rd_count), 32'd4);

    // Eight pop/fill rounds wrap both pointers twice
    m_rd = 2;
    m_wr = 2;
    for (int i = 0; i < 8; i++) begin
      pop_ch(2'd0);
      m_rd = (m_rd + 1) % 4;
      check($sformatf("wrap%0d rd_slot", i), 32'(rd_slot), 32'(m_rd));
      check($sformatf("wrap%0d rd_len", i), 32'(rd_len), 32'(exp_len[m_rd]));
      check($sformatf("wrap%0d count3", i), 32'(rd_count), 32'd3);
      send_frame(16'h1000, 5 + i, -1, 1'b1, 0, m_wr, 8'(8'h90 + 8'(i)), 1'b0);
      exp_len[m_wr] = 5 + i;
      m_wr = (m_wr + 1) % 4;
      @(negedge RX_CLK);
      check($sformatf("wrap%0d count4", i), 32'(rd_count), 32'd4);
    end

    // Unmatched port and disabled channel: no writes, no drop
    send_frame(16'h9999, 10, -1, 1'b0, 0, 0, 8'hA0, 1'b0);
    @(negedge RX_CLK);
    check("unmatched drop_cnt", 32'(drop_cnt), 32'd2);
    chan_en = 4'b0111;
    send_frame(16'h3000, 6, -1, 1'b0, 3, 0, 8'hB0, 1'b0);
    @(negedge RX_CLK);
    check("disabled drop_cnt", 32'(drop_cnt), 32'd2);
    rd_chan = 2'd3;
    #1;
    check("disabled rd_count", 32'(rd_count), 32'd0);
    chan_en = 4'hF;

    // Two channels on the same port: lowest index (ch2) wins
    port_table[63:48] = 16'h2000;
    send_frame(16'h2000, 6, -1, 1'b1, 2, 1, 8'hC0, 1'b0);
    @(negedge RX_CLK);
    rd_chan = 2'd2;
    #1;
    check("tie ch2 rd_count", 32'(rd_count), 32'd2);
    rd_chan = 2'd3;
    #1;
    check("tie ch3 rd_count", 32'(rd_count), 32'd0);
    port_table[63:48] = 16'h3000;
    check("pre-reset irq", 32'(rx_irq), 32'h5);

    // Reset asserted mid-frame
    rd_chan = 2'd0;
    @(negedge RX_CLK);
    rx_dst_port   = 16'h3000;
    rx_udp_data_v = 1'b1;
    rx_udp_data   = 8'hD0;
    @(negedge RX_CLK);
    rx_udp_data = 8'hD1;
    check("mid mem_we", 32'(mem_we), 32'd1);
    check("mid state", 32'(dbg_state), 32'(RECV));
    #2 rst_n = 1'b0;
    #1;
    check("arst mem_we", 32'(mem_we), 32'd0);
    check("arst mem_addr", 32'(mem_addr), 32'd0);
    check("arst mem_wdata", 32'(mem_wdata), 32'd0);
    check("arst rx_irq", 32'(rx_irq), 32'd0);
    check("arst drop_cnt", 32'(drop_cnt), 32'd0);
    check("arst state", 32'(dbg_state), 32'(IDLE));
    rx_udp_data_v = 1'b0;
    @(negedge RX_CLK);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      rd_chan = 2'(c);
      #1;
      check($sformatf("arst count ch%0d", c), 32'(rd_count), 32'd0);
    end

    // Ch3 starts cleanly at slot 0 after reset
    send_frame(16'h3000, 8, -1, 1'b1, 3, 0, 8'hE0, 1'b0);
    @(negedge RX_CLK);
    rd_chan = 2'd3;
    #1;
    check("post-reset rd_count", 32'(rd_count), 32'd1);
    check("post-reset rd_len", 32'(rd_len), 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
